// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one combinational multiplier between two requesters.
// Define MUL_OUT_REG_EN to add a product stage register and an extra WAIT state.
module mul_share_arbiter #(
   parameter int width = 12,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [width-1:0]     req0_A,
   input  logic [width-1:0]     req0_B,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [width-1:0]     req1_A,
   input  logic [width-1:0]     req1_B,
   output logic [width-1:0]     mul_A,
   output logic [width-1:0]     mul_B,
   input  logic [2*width-1:0]   mul_S,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [2*width-1:0]   rsp_S,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic [width-1:0]     op_a_q, op_a_d;
   logic [width-1:0]     op_b_q, op_b_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [2*width-1:0]   rsp_s_q, rsp_s_d;
   logic                 rsp_id_q, rsp_id_d;
   logic [CNT_W-1:0]     op_count_q, op_count_d;
`ifdef MUL_OUT_REG_EN
   logic [2*width-1:0]   stage_q, stage_d;
`endif
   logic                 any_valid_s;
   logic                 grant_s;
   logic                 accept_s;

   // Arbitration: a lone requester wins; when both are valid the one not served last wins.
   always_comb begin
      any_valid_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_grant_q;
      end else if (req0_valid) begin
         grant_s = 1'b0;
      end else begin
         grant_s = 1'b1;
      end
      accept_s   = (state_q == S_IDLE) && any_valid_s && !rst;
      req0_ready = accept_s && (grant_s == 1'b0);
      req1_ready = accept_s && (grant_s == 1'b1);
   end

   // Sequencer next-state and datapath updates.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_s_d      = rsp_s_q;
      rsp_id_d     = rsp_id_q;
      op_count_d   = op_count_q;
`ifdef MUL_OUT_REG_EN
      stage_d      = stage_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               op_a_d       = grant_s ? req1_A : req0_A;
               op_b_d       = grant_s ? req1_B : req0_B;
               rsp_id_d     = grant_s;
               last_grant_d = grant_s;
               state_d      = S_CALC;
            end else begin
               state_d      = S_IDLE;
            end
         end
         S_CALC: begin
`ifdef MUL_OUT_REG_EN
            stage_d     = mul_S;
            state_d     = S_WAIT;
`else
            rsp_s_d     = mul_S;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
`endif
         end
`ifdef MUL_OUT_REG_EN
         S_WAIT: begin
            rsp_s_d     = stage_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
`endif
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_d     = S_IDLE;
            end else begin
               state_d     = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         op_a_q       <= {width{1'b0}};
         op_b_q       <= {width{1'b0}};
         rsp_valid_q  <= 1'b0;
         rsp_s_q      <= {(2*width){1'b0}};
         rsp_id_q     <= 1'b0;
         op_count_q   <= {CNT_W{1'b0}};
`ifdef MUL_OUT_REG_EN
         stage_q      <= {(2*width){1'b0}};
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_s_q      <= rsp_s_d;
         rsp_id_q     <= rsp_id_d;
         op_count_q   <= op_count_d;
`ifdef MUL_OUT_REG_EN
         stage_q      <= stage_d;
`endif
      end
   end

   assign mul_A     = op_a_q;
   assign mul_B     = op_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_S     = rsp_s_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = op_count_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed scenarios plus a randomized run,
// all checked cycle-by-cycle against a transaction-level reference model.
module tb_mul_share_arbiter;

   localparam int W     = 12;
   localparam int CNT_W = 16;
`ifdef MUL_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]     req0_A, req0_B, req1_A, req1_B;
   logic [W-1:0]     mul_A, mul_B;
   logic [2*W-1:0]   mul_S;
   logic             rsp_valid, rsp_ready, rsp_id, busy;
   logic [2*W-1:0]   rsp_S;
   logic [CNT_W-1:0] op_count;

   always #5 clk = ~clk;

   assign mul_S = 24'(mul_A) * 24'(mul_B);

   mul_share_arbiter #(.width(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
      .mul_A(mul_A), .mul_B(mul_B), .mul_S(mul_S),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_S(rsp_S),
      .busy(busy), .op_count(op_count)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: one transaction in flight at a time, alternation on contention.
   logic        m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic [23:0] m_exp = '0;
   logic [15:0] m_count = '0;
   int          m_acc_cyc = 0;
   int          acc0_cnt = 0, acc1_cnt = 0;
   logic        any_v, g, e0, e1, m_rv;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         check_val("ready_in_reset", {30'd0, req1_ready, req0_ready}, 32'd0);
         m_busy  = 1'b0;
         m_last  = 1'b1;
         m_count = 16'd0;
      end else begin
         any_v = req0_valid | req1_valid;
         g     = (req0_valid && req1_valid) ? ~m_last : ~req0_valid;
         e0    = ~m_busy & any_v & ~g;
         e1    = ~m_busy & any_v & g;
         m_rv  = m_busy && ((cyc - m_acc_cyc) >= LAT);
         check_val("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
         check_val("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
         check_val("busy", {31'd0, busy}, {31'd0, m_busy});
         check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
         check_val("op_count", {16'd0, op_count}, {16'd0, m_count});
         if (m_busy) begin
            check_val("mul_A", {20'd0, mul_A}, {20'd0, m_a});
            check_val("mul_B", {20'd0, mul_B}, {20'd0, m_b});
         end
         if (m_rv) begin
            check_val("rsp_S", {8'd0, rsp_S}, {8'd0, m_exp});
            check_val("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
         end
         if (m_rv && rsp_ready) begin
            m_busy  = 1'b0;
            m_count = m_count + 16'd1;
         end else if (e0) begin
            m_busy = 1'b1; m_id = 1'b0; m_last = 1'b0; m_acc_cyc = cyc;
            m_a = req0_A; m_b = req0_B; m_exp = 24'(req0_A) * 24'(req0_B);
            acc0_cnt++;
         end else if (e1) begin
            m_busy = 1'b1; m_id = 1'b1; m_last = 1'b1; m_acc_cyc = cyc;
            m_a = req1_A; m_b = req1_B; m_exp = 24'(req1_A) * 24'(req1_B);
            acc1_cnt++;
         end
      end
   end

   // Requester behaviour: drop or refresh operands once accepted.
   int  seen0 = 0, seen1 = 0, rnd_base = 0;
   bit  rnd_mode = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (acc0_cnt != seen0) begin
         seen0 = acc0_cnt;
         if (rnd_mode) begin
            req0_A = W'($urandom_range(0, 4095));
            req0_B = W'($urandom_range(0, 4095));
         end else begin
            req0_valid = 1'b0;
         end
      end
      if (acc1_cnt != seen1) begin
         seen1 = acc1_cnt;
         if (rnd_mode) begin
            req1_A = W'($urandom_range(0, 4095));
            req1_B = W'($urandom_range(0, 4095));
         end else begin
            req1_valid = 1'b0;
         end
      end
      if (rnd_mode) begin
         rsp_ready = 1'($urandom_range(0, 1));
         if ((acc0_cnt + acc1_cnt - rnd_base) >= 50) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 20 && !rsp_valid; i++) step();
      check_val(tag, {31'd0, rsp_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int t_acc;
   logic [W-1:0] a3, b3;

   initial begin
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_rsp_S", {8'd0, rsp_S}, 32'd0);
      check_val("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      check_val("rst_op_count", {16'd0, op_count}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_mul_A", {20'd0, mul_A}, 32'd0);
      check_val("rst_mul_B", {20'd0, mul_B}, 32'd0);

      // single request, latency and product
      req0_A = 12'd100; req0_B = 12'd200; req0_valid = 1'b1;
      #1;
      check_val("t1_ready", {31'd0, req0_ready}, 32'd1);
      t_acc = cyc;
      step();
      check_val("t1_ready_gone", {31'd0, req0_ready}, 32'd0);
      wait_rsp("t1_rsp_timeout");
      check_val("t1_latency", cyc - t_acc, LAT);
      check_val("t1_rsp_S", {8'd0, rsp_S}, 32'd20000);
      check_val("t1_rsp_id", {31'd0, rsp_id}, 32'd0);
      step();
      check_val("t1_op_count", {16'd0, op_count}, 32'd1);
      check_val("t1_idle", {31'd0, busy}, 32'd0);

      // contention after reset: req0 first, req1 waits for retirement
      do_reset();
      req0_A = 12'd4095; req0_B = 12'd4095; req0_valid = 1'b1;
      req1_A = 12'd3;    req1_B = 12'd5;    req1_valid = 1'b1;
      #1;
      wait_rsp("t2_rsp0_timeout");
      check_val("t2_rsp0_S", {8'd0, rsp_S}, 32'd16769025);
      check_val("t2_rsp0_id", {31'd0, rsp_id}, 32'd0);
      check_val("t2_req1_held", {31'd0, req1_ready}, 32'd0);
      step();
      wait_rsp("t2_rsp1_timeout");
      check_val("t2_rsp1_S", {8'd0, rsp_S}, 32'd15);
      check_val("t2_rsp1_id", {31'd0, rsp_id}, 32'd1);
      step();

      // backpressure in RESP
      rsp_ready = 1'b0;
      a3 = W'($urandom_range(0, 4095)); b3 = W'($urandom_range(0, 4095));
      req0_A = a3; req0_B = b3; req0_valid = 1'b1;
      step();
      req1_A = 12'd1; req1_B = 12'd1; req1_valid = 1'b1;
      wait_rsp("t3_rsp_timeout");
      for (int i = 0; i < 5; i++) begin
         check_val("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check_val("t3_hold_S", {8'd0, rsp_S}, {8'd0, 24'(a3) * 24'(b3)});
         check_val("t3_hold_id", {31'd0, rsp_id}, 32'd0);
         check_val("t3_hold_busy", {31'd0, busy}, 32'd1);
         check_val("t3_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      check_val("t3_retired", {31'd0, rsp_valid}, 32'd0);
      check_val("t3_idle", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 20 && (req1_valid || busy); i++) step();
      check_val("t3_drain", {30'd0, req1_valid, busy}, 32'd0);

      // reset while computing
      do_reset();
      req0_A = 12'd11; req0_B = 12'd13; req0_valid = 1'b1;
      step();
      check_val("t4_in_calc", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val("t4_no_rsp", {31'd0, rsp_valid}, 32'd0);
         check_val("t4_count", {16'd0, op_count}, 32'd0);
         step();
      end
      req1_A = 12'd7; req1_B = 12'd9; req1_valid = 1'b1;
      #1;
      check_val("t4_ready", {31'd0, req1_ready}, 32'd1);
      t_acc = cyc;
      step();
      wait_rsp("t4_rsp_timeout");
      check_val("t4_latency", cyc - t_acc, LAT);
      check_val("t4_rsp_S", {8'd0, rsp_S}, 32'd63);
      check_val("t4_rsp_id", {31'd0, rsp_id}, 32'd1);
      step();

      // randomized contention with random backpressure
      do_reset();
      rnd_base = acc0_cnt + acc1_cnt;
      t_acc = acc0_cnt;
      rnd_mode = 1'b1;
      req0_A = W'($urandom_range(0, 4095)); req0_B = W'($urandom_range(0, 4095));
      req1_A = W'($urandom_range(0, 4095)); req1_B = W'($urandom_range(0, 4095));
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 3000 && !((acc0_cnt + acc1_cnt - rnd_base) >= 50 && !busy); i++) step();
      rnd_mode = 1'b0;
      rsp_ready = 1'b1;
      step();
      check_val("t5_op_count", {16'd0, op_count}, 32'd50);
      check_val("t5_req0_ops", acc0_cnt - t_acc, 32'd25);
      check_val("t5_req1_ops", acc1_cnt - (rnd_base - t_acc), 32'd25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
